// File: rtl/thor2025_pkg.sv
// Shared Thor2025 rename-map types: checkpoint id width and default checkpoint count.
package thor2025_pkg;

    localparam int NCHECK_DFLT = 8;

    typedef logic [$clog2(NCHECK_DFLT)-1:0] checkpoint_id_t;

endpackage

// File: rtl/thor2025_checkpoint_ctrl.sv
// Rename-map checkpoint allocator: grants copy strobes on branch enqueue, frees in
// retire order, and rewinds the active map index on a branch miss or exception.
module thor2025_checkpoint_ctrl
    import thor2025_pkg::*;
#(
    parameter int NCHECK      = NCHECK_DFLT,
    parameter int RESTORE_CYC = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alloc_req,
    input  logic                      free_req,
    input  logic                      restore,
    input  logic [$clog2(NCHECK)-1:0] restore_id,
    output logic [$clog2(NCHECK)-1:0] ndx,
    output logic                      cp,
    output logic                      alloc_gnt,
    output logic [$clog2(NCHECK)-1:0] alloc_id,
    output logic [$clog2(NCHECK)-1:0] count,
    output logic                      full,
    output logic                      empty,
    output logic                      stall,
    output logic                      restore_err
);

    localparam int IW = $clog2(NCHECK);

    typedef enum logic {CK_RUN = 1'b0, CK_RECOVER = 1'b1} ckpt_state_t;

    ckpt_state_t   state_r;
    logic [IW-1:0] head_r;
    logic [IW-1:0] tail_r;
    logic [IW-1:0] count_r;
    logic [3:0]    rcnt_r;
    logic          err_r;

    logic          free_ok_s;
    logic [IW-1:0] tail_n_s;
    logic [IW-1:0] count_n_s;
    logic [IW-1:0] dist_s;
    logic          restore_ok_s;
    logic          full_s;
    logic          gnt_s;

    // The free is applied before judging the restore window, so a restore may not
    // target the checkpoint being retired in the same cycle.
    assign free_ok_s    = free_req & (count_r != {IW{1'b0}});
    assign tail_n_s     = tail_r + IW'(free_ok_s);
    assign count_n_s    = count_r - IW'(free_ok_s);
    assign dist_s       = restore_id - tail_n_s;
    assign restore_ok_s = (dist_s <= count_n_s);

    assign full_s = (count_r == IW'(NCHECK - 1));
    assign gnt_s  = alloc_req & (state_r == CK_RUN) & ~restore & ~full_s;

    assign ndx         = head_r;
    assign cp          = gnt_s;
    assign alloc_gnt   = gnt_s;
    assign alloc_id    = head_r + {{(IW-1){1'b0}}, 1'b1};
    assign count       = count_r;
    assign full        = full_s;
    assign empty       = (count_r == {IW{1'b0}});
    assign stall       = full_s | (state_r == CK_RECOVER) | restore;
    assign restore_err = err_r;

    // Checkpoint window, recovery sequencing and sticky restore error.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= {IW{1'b0}};
            tail_r  <= {IW{1'b0}};
            count_r <= {IW{1'b0}};
            state_r <= CK_RUN;
            rcnt_r  <= 4'd0;
            err_r   <= 1'b0;
        end else if (restore) begin
            tail_r <= tail_n_s;
            if (restore_ok_s) begin
                head_r  <= restore_id;
                count_r <= dist_s;
                state_r <= CK_RECOVER;
                rcnt_r  <= 4'(RESTORE_CYC - 1);
            end else begin
                count_r <= count_n_s;
                err_r   <= 1'b1;
            end
        end else begin
            tail_r  <= tail_n_s;
            head_r  <= head_r + IW'(gnt_s);
            count_r <= count_n_s + IW'(gnt_s);
            if (state_r == CK_RECOVER) begin
                if (rcnt_r == 4'd0) begin
                    state_r <= CK_RUN;
                end else begin
                    rcnt_r <= rcnt_r - 4'd1;
                end
            end else begin
                state_r <= CK_RUN;
            end
        end
    end

endmodule

// File: tb/tb_thor2025_checkpoint_ctrl.sv
// Directed bench for thor2025_checkpoint_ctrl with a window-level reference model
// checked every cycle plus literal expectations at the scenario points.
module tb_thor2025_checkpoint_ctrl;

    localparam int N  = 8;
    localparam int RC = 1;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          alloc_req = 1'b0;
    logic          free_req = 1'b0;
    logic          restore = 1'b0;
    logic [IW-1:0] restore_id = 3'd0;
    logic [IW-1:0] ndx, alloc_id, count;
    logic          cp, alloc_gnt, full, empty, stall, restore_err;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // model: live window [tail, tail+count), head = active index, left = stall cycles to go
    int m_head, m_tail, m_count, m_left;
    bit m_err;

    always #5 clk = ~clk;

    thor2025_checkpoint_ctrl #(.NCHECK(N), .RESTORE_CYC(RC)) dut (
        .clk(clk), .rst(rst), .alloc_req(alloc_req), .free_req(free_req),
        .restore(restore), .restore_id(restore_id), .ndx(ndx), .cp(cp),
        .alloc_gnt(alloc_gnt), .alloc_id(alloc_id), .count(count), .full(full),
        .empty(empty), .stall(stall), .restore_err(restore_err)
    );

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_gnt();
        return alloc_req && (m_left == 0) && !restore && (m_count != N - 1);
    endfunction

    // per-cycle compare of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_ndx",      ndx,         m_head);
            chk("m_alloc_id", alloc_id,    (m_head + 1) % N);
            chk("m_count",    count,       m_count);
            chk("m_full",     full,        m_count == N - 1);
            chk("m_empty",    empty,       m_count == 0);
            chk("m_gnt",      alloc_gnt,   m_gnt());
            chk("m_cp",       cp,          m_gnt());
            chk("m_stall",    stall,       (m_count == N - 1) || (m_left > 0) || restore);
            chk("m_err",      restore_err, m_err);
        end
    end

    task automatic model_update();
        int fr, nt, nc, d, g;
        if (rst) begin
            m_head = 0; m_tail = 0; m_count = 0; m_left = 0; m_err = 1'b0;
        end else begin
            fr = (free_req && m_count > 0) ? 1 : 0;
            nt = (m_tail + fr) % N;
            nc = m_count - fr;
            if (restore) begin
                d = (int'(restore_id) - nt + N) % N;
                if (d <= nc) begin
                    m_head = restore_id; m_count = d; m_left = RC;
                end else begin
                    m_err = 1'b1; m_count = nc;
                end
            end else begin
                g = m_gnt() ? 1 : 0;
                m_head  = (m_head + g) % N;
                m_count = nc + g;
                if (m_left > 0) m_left = m_left - 1;
            end
            m_tail = nt;
        end
    endtask

    task automatic drive(input bit a, input bit f, input bit r, input int rid);
        alloc_req = a; free_req = f; restore = r; restore_id = IW'(rid);
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ndx"}, ndx, 0);
        chk({tag, "_alloc_id"}, alloc_id, 1);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_cp"}, cp, 0);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_stall"}, stall, 0);
        chk({tag, "_err"}, restore_err, 0);
    endtask

    initial begin
        drive(0, 0, 0, 0);
        tick(); chk_en = 1'b1; tick();
        rst = 1'b0;

        drive(0, 0, 0, 0); chk_reset_vals("reset"); tick();

        for (int i = 1; i <= 7; i++) begin
            drive(1, 0, 0, 0);
            chk("fill_gnt", alloc_gnt, 1);
            chk("fill_id", alloc_id, i);
            tick();
        end
        drive(1, 0, 0, 0);
        chk("full_gnt", alloc_gnt, 0); chk("full_flag", full, 1);
        chk("full_stall", stall, 1); chk("full_count", count, 7);
        tick();

        drive(1, 1, 0, 0); chk("full_free_gnt", alloc_gnt, 0); tick();
        drive(1, 0, 0, 0);
        chk("after_free_count", count, 6); chk("wrap_gnt", alloc_gnt, 1);
        chk("wrap_id", alloc_id, 0);
        tick();
        drive(0, 0, 0, 0); chk("wrap_ndx", ndx, 0); chk("wrap_count", count, 7); tick();

        // build head=5 tail=2 count=3
        rst = 1'b1; drive(0, 0, 0, 0); tick(); rst = 1'b0;
        for (int i = 0; i < 5; i++) begin drive(1, 0, 0, 0); tick(); end
        for (int i = 0; i < 2; i++) begin drive(0, 1, 0, 0); tick(); end
        drive(0, 0, 1, 3);
        chk("rs_pre_ndx", ndx, 5); chk("rs_pre_count", count, 3);
        chk("rs_stall0", stall, 1); chk("rs_cp0", cp, 0);
        tick();
        drive(1, 0, 0, 0);
        chk("rs_ndx", ndx, 3); chk("rs_count", count, 1);
        chk("rs_stall1", stall, 1); chk("rs_gnt1", alloc_gnt, 0);
        tick();
        drive(1, 0, 0, 0);
        chk("rs_stall2", stall, 0); chk("rs_gnt2", alloc_gnt, 1); chk("rs_id", alloc_id, 4);
        tick();
        drive(1, 0, 0, 0); chk("rs_id5", alloc_id, 5); tick();

        // head=5 tail=2 count=3: restore to 2 while freeing 2 -> outside window
        drive(0, 1, 1, 2); tick();
        drive(0, 0, 0, 0);
        chk("bad_err", restore_err, 1); chk("bad_count", count, 2);
        chk("bad_ndx", ndx, 5); chk("bad_stall", stall, 0);
        tick();

        drive(1, 0, 1, 4);
        chk("ar_cp", cp, 0); chk("ar_gnt", alloc_gnt, 0); chk("ar_stall", stall, 1);
        tick();
        rst = 1'b1;
        drive(1, 1, 0, 0);
        chk("ar_ndx", ndx, 4); chk("ar_count", count, 1); chk("ar_stall1", stall, 1);
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0); chk_reset_vals("rstrec"); tick();

        // free on empty must not move tail: a restore to 0 later stays valid
        drive(0, 1, 0, 0); tick();
        drive(0, 0, 0, 0); chk("fe_count", count, 0); chk("fe_empty", empty, 1); tick();
        drive(1, 0, 0, 0); tick();
        drive(0, 0, 1, 0); tick();
        drive(0, 0, 0, 0);
        chk("fe_err", restore_err, 0); chk("fe_ndx", ndx, 0); chk("fe_count", count, 0);
        tick();
        drive(0, 0, 0, 0); tick();

        // mixed traffic, checked by the per-cycle model compare
        for (int i = 0; i < 48; i++) begin
            drive((i % 3) != 0, (i % 4) == 1, (i % 11) == 5, (i * 3) % N);
            tick();
        end
        drive(0, 0, 0, 0); tick();
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
